quad_encoder_gen: RTL and testbench

Quadrature encoder signal generator: transmit side of the A/B encoder interface consumed by the user-project encoder decoders. On command it emits a programmed number of quadrature edges at a programmed rate, in either direction, and tracks the resulting signed position. Used to drive `enc*_a`/`enc*_b` pads in self-test mode and as a motor-feedback emulator for closed-loop PWM bring-up.

---
 rtl/quad_encoder_gen.sv | 113 +++++++++++
 tb/tb_quad_encoder_gen.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/quad_encoder_gen.sv
// Quadrature A/B edge generator: emits a commanded number of edges at a fixed
// cycle spacing in either direction and keeps a signed edge-position count.
//
// state | meaning
// IDLE  | ready for a command; pulses done one cycle after a zero-step command
// RUN   | counting down between edges, emitting edges until remaining hits zero
module quad_encoder_gen #(
   parameter int STEPS_W  = 16,
   parameter int PERIOD_W = 16,
   parameter int POS_W    = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic                cmd_dir,
   input  logic [STEPS_W-1:0]  cmd_steps,
   input  logic [PERIOD_W-1:0] cmd_period,
   input  logic                abort,
   input  logic                pos_clear,
   output logic                enc_a,
   output logic                enc_b,
   output logic                busy,
   output logic                done,
   output logic [POS_W-1:0]    position
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t              state;
   logic                dir_q;
   logic [PERIOD_W-1:0] period_q;
   logic [PERIOD_W-1:0] timer;
   logic [STEPS_W-1:0]  remaining;
   logic [1:0]          phase;
   logic                zero_pend;

   logic [PERIOD_W-1:0] period_eff;
   logic [1:0]          phase_next;
   logic                edge_fire;

   always_comb begin
      period_eff = (cmd_period == '0) ? PERIOD_W'(1) : cmd_period;
      phase_next = dir_q ? (phase - 2'd1) : (phase + 2'd1);
      edge_fire  = (state == RUN) && !abort && (timer == '0);
   end

   assign busy      = (state == RUN);
   assign cmd_ready = !busy;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         dir_q     <= 1'b0;
         period_q  <= PERIOD_W'(1);
         timer     <= '0;
         remaining <= '0;
         phase     <= 2'd0;
         zero_pend <= 1'b0;
         enc_a     <= 1'b0;
         enc_b     <= 1'b0;
         done      <= 1'b0;
         position  <= '0;
      end else begin
         done      <= 1'b0;
         zero_pend <= 1'b0;

         // Clear has priority over an edge landing in the same cycle.
         if (pos_clear)
            position <= '0;
         else if (edge_fire)
            position <= dir_q ? (position - POS_W'(1)) : (position + POS_W'(1));

         case (state)
            IDLE: begin
               if (zero_pend)
                  done <= 1'b1;
               if (cmd_valid) begin
                  dir_q     <= cmd_dir;
                  period_q  <= period_eff;
                  timer     <= period_eff - PERIOD_W'(1);
                  remaining <= cmd_steps;
                  if (cmd_steps == '0)
                     zero_pend <= 1'b1;
                  else
                     state <= RUN;
               end
            end
            RUN: begin
               if (abort) begin
                  state <= IDLE;
                  done  <= 1'b1;
               end else if (timer == '0) begin
                  // Gray-coded phase: (A,B) = 00,10,11,01 for phase 0..3.
                  phase     <= phase_next;
                  enc_a     <= phase_next[1] ^ phase_next[0];
                  enc_b     <= phase_next[1];
                  remaining <= remaining - STEPS_W'(1);
                  timer     <= period_q - PERIOD_W'(1);
                  if (remaining == STEPS_W'(1)) begin
                     state <= IDLE;
                     done  <= 1'b1;
                  end
               end else begin
                  timer <= timer - PERIOD_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_quad_encoder_gen.sv
// Directed plus random commands for quad_encoder_gen, checked cycle by cycle
// against an edge-count model derived from accept time, period and step count.
module tb_quad_encoder_gen;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_dir;
   logic [15:0] cmd_steps;
   logic [15:0] cmd_period;
   logic        abort;
   logic        pos_clear;
   logic        enc_a;
   logic        enc_b;
   logic        busy;
   logic        done;
   logic [15:0] position;

   int          n_assert = 0;
   int          n_fail   = 0;
   int          m_phase  = 0;
   logic [15:0] m_pos    = '0;

   always #5 clk = ~clk;

   quad_encoder_gen #(.STEPS_W(16), .PERIOD_W(16), .POS_W(16)) dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .cmd_period(cmd_period),
      .abort(abort), .pos_clear(pos_clear), .enc_a(enc_a), .enc_b(enc_b),
      .busy(busy), .done(done), .position(position)
   );

   function automatic logic [1:0] pads_of(input int ph);
      case (ph % 4)
         0:       return 2'b00;
         1:       return 2'b10;
         2:       return 2'b11;
         default: return 2'b01;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic exp_busy, input logic exp_done);
      chk({tag, ".pads"}, {30'd0, enc_a, enc_b}, {30'd0, pads_of(m_phase)});
      chk({tag, ".busy"}, {31'd0, busy}, {31'd0, exp_busy});
      chk({tag, ".ready"}, {31'd0, cmd_ready}, {31'd0, !exp_busy});
      chk({tag, ".done"}, {31'd0, done}, {31'd0, exp_done});
      chk({tag, ".pos"}, {16'd0, position}, {16'd0, m_pos});
   endtask

   // abort_k > 0: raise abort right after the abort_k-th edge is seen.
   // clear_t > 0: pos_clear sampled on the clear_t-th clock after accept.
   // poke: present a foreign command while running; it must be ignored.
   task automatic run_cmd(input logic dir, input int steps, input int period,
                          input int abort_k, input int clear_t, input bit poke);
      int  p;
      int  t;
      int  edges;
      bit  fin;
      bit  abort_now;
      bit  clear_now;
      bit  last;
      p     = (period == 0) ? 1 : period;
      edges = 0;
      fin   = 1'b0;
      t     = 0;
      cmd_valid  = 1'b1;
      cmd_dir    = dir;
      cmd_steps  = 16'(steps);
      cmd_period = 16'(period);
      tick();
      cmd_valid = 1'b0;
      if (steps == 0) begin
         check_all("zero_acc", 1'b0, 1'b0);
         tick();
         check_all("zero_done", 1'b0, 1'b1);
         tick();
         check_all("zero_after", 1'b0, 1'b0);
         return;
      end
      check_all("accept", 1'b1, 1'b0);
      while (!fin) begin
         t++;
         abort_now = (abort_k > 0) && (edges == abort_k);
         clear_now = (t == clear_t);
         abort     = abort_now;
         pos_clear = clear_now;
         if (poke && t == 1) begin
            cmd_valid  = 1'b1;
            cmd_dir    = !dir;
            cmd_steps  = 16'($urandom_range(1, 20));
            cmd_period = 16'($urandom_range(0, 5));
         end
         tick();
         abort     = 1'b0;
         pos_clear = 1'b0;
         cmd_valid = 1'b0;
         last      = 1'b0;
         if (!abort_now && (t % p == 0)) begin
            edges++;
            m_phase = (m_phase + (dir ? 3 : 1)) % 4;
            m_pos   = dir ? (m_pos - 16'd1) : (m_pos + 16'd1);
            last    = (edges == steps);
         end
         if (clear_now)
            m_pos = '0;
         check_all("run", !(abort_now || last), abort_now || last);
         fin = abort_now || last;
         if (!fin && t > steps * p + 2) begin
            chk("run_timeout", 32'(t), 32'(steps * p));
            fin = 1'b1;
         end
      end
      tick();
      check_all("post", 1'b0, 1'b0);
   endtask

   initial begin
      reset      = 1'b1;
      cmd_valid  = 1'b0;
      cmd_dir    = 1'b0;
      cmd_steps  = '0;
      cmd_period = '0;
      abort      = 1'b0;
      pos_clear  = 1'b0;
      tick();
      tick();
      check_all("reset", 1'b0, 1'b0);
      reset = 1'b0;
      tick();
      check_all("idle", 1'b0, 1'b0);

      // Forward 4 edges at period 3.
      run_cmd(1'b0, 4, 3, 0, 0, 1'b0);
      chk("fwd4_pos", {16'd0, position}, 32'd4);

      pos_clear = 1'b1;
      tick();
      pos_clear = 1'b0;
      m_pos = '0;
      check_all("clear_idle", 1'b0, 1'b0);

      // Reverse 5 at period 1, then forward resumes from phase 3.
      run_cmd(1'b1, 5, 1, 0, 0, 1'b0);
      chk("rev5_pos", {16'd0, position}, 32'h0000_FFFB);
      run_cmd(1'b0, 2, 2, 0, 0, 1'b0);

      run_cmd(1'b0, 0, 7, 0, 0, 1'b0);
      run_cmd(1'b1, 6, 2, 0, 0, 1'b1);

      abort = 1'b1;
      tick();
      abort = 1'b0;
      check_all("abort_idle", 1'b0, 1'b0);

      // Abort after the third edge of a long command.
      pos_clear = 1'b1;
      tick();
      pos_clear = 1'b0;
      m_pos = '0;
      run_cmd(1'b0, 100, 2, 3, 0, 1'b0);
      chk("abort_pos", {16'd0, position}, 32'd3);

      run_cmd(1'b1, 3, 0, 0, 0, 1'b0);
      run_cmd(1'b0, 4, 2, 0, 4, 1'b0);
      chk("clear_edge_pos", {16'd0, position}, 32'd2);

      // Signed wrap at both ends.
      pos_clear = 1'b1;
      tick();
      pos_clear = 1'b0;
      m_pos = '0;
      run_cmd(1'b1, 1, 1, 0, 0, 1'b0);
      chk("wrap_neg", {16'd0, position}, 32'h0000_FFFF);
      run_cmd(1'b0, 1, 1, 0, 0, 1'b0);
      run_cmd(1'b0, 32767, 1, 0, 0, 1'b0);
      chk("pos_max", {16'd0, position}, 32'h0000_7FFF);
      run_cmd(1'b0, 1, 1, 0, 0, 1'b0);
      chk("wrap_pos", {16'd0, position}, 32'h0000_8000);

      // Reset in the middle of a run.
      cmd_valid  = 1'b1;
      cmd_dir    = 1'b0;
      cmd_steps  = 16'd50;
      cmd_period = 16'd2;
      tick();
      cmd_valid = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      reset = 1'b1;
      tick();
      reset   = 1'b0;
      m_phase = 0;
      m_pos   = '0;
      check_all("mid_reset", 1'b0, 1'b0);
      run_cmd(1'b0, 3, 1, 0, 0, 1'b0);

      for (int n = 0; n < 25; n++) begin
         int s;
         int per;
         int p_eff;
         int ak;
         int ct;
         s     = int'($urandom_range(0, 12));
         per   = int'($urandom_range(0, 4));
         p_eff = (per == 0) ? 1 : per;
         ak    = 0;
         ct    = 0;
         if (s >= 2 && ($urandom % 3) == 0)
            ak = int'($urandom_range(1, s - 1));
         if (s >= 1 && ($urandom % 4) == 0)
            ct = int'($urandom_range(1, s * p_eff));
         run_cmd(1'($urandom % 2), s, per, ak, ct, 1'($urandom % 2));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
